// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo pipeline output path.
package stereo_pkg;

    localparam int IMAGE_WIDTH  = 640;
    localparam int IMAGE_HEIGHT = 480;
    localparam int MAXDISPARITY = 64;
    localparam int SOF_BIT      = 8;
    localparam int DISP_W       = 8;

    typedef struct packed {
        logic              tuser;
        logic              tlast;
        logic [DISP_W-1:0] data;
    } axis_word_t;

    typedef enum logic {
        ST_UNSYNCED,
        ST_SYNCED
    } sync_state_t;

    // Left shift that clamps to full scale instead of wrapping.
    function automatic logic [DISP_W-1:0] sat_shift(input logic [DISP_W-1:0] d,
                                                    input int unsigned       sh);
        logic [2*DISP_W-1:0] w_wide;
        w_wide = {{DISP_W{1'b0}}, d} << sh;
        return (w_wide[2*DISP_W-1:DISP_W] != '0) ? '1 : w_wide[DISP_W-1:0];
    endfunction

endpackage

// File: rtl/disparity_axis_tx_if.sv
// AXI4-Stream video bus carrying 8-bit pixels with frame/line markers.
interface disparity_axis_tx_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tuser;
    logic       tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/axis_word_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible while not empty.
module axis_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; only the pointers define what is valid, so
    // clearing the array would just add reset fan-out for no behavioural gain.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    // NOTE: state is always updated with <= so every register samples the
    // pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/disparity_axis_tx.sv
// Recovers frame position from the SOF-tagged disparity stream, maps it to
// pixels and re-emits it as an AXI4-Stream video master through a small FIFO.
module disparity_axis_tx #(
    parameter int IMAGE_WIDTH  = stereo_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = stereo_pkg::IMAGE_HEIGHT,
    parameter int INPUTDATAWID = 9,
    parameter int FIFO_DEPTH   = 16,
    parameter int DISP_SHIFT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    pixelEN,
    input  logic [INPUTDATAWID-1:0] disparity,
    input  logic                    show_color_depth,
    disparity_axis_tx_if.master     m_axis,
    output logic                    overflow,
    output logic                    frame_err
);

    import stereo_pkg::*;

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    sync_state_t      r_state, w_state_next;
    logic [COL_W-1:0] r_col, w_word_col, w_col_next;
    logic [ROW_W-1:0] r_row, w_word_row, w_row_next;
    logic             w_acc, w_sof, w_at_origin, w_word_last;
    logic             w_word_valid, w_frame_err_set;
    logic [7:0]       w_pixel;
    axis_word_t       w_word, r_stage_word, w_head;
    logic             r_stage_valid;
    logic             w_push, w_pop, w_full, w_empty;

    assign w_acc       = en & pixelEN;
    assign w_sof       = disparity[SOF_BIT];
    assign w_at_origin = (r_col == '0) && (r_row == '0);

    // A SOF word always lands at the origin, whatever the counters expected.
    always_comb begin
        w_word_col  = w_sof ? '0 : r_col;
        w_word_row  = w_sof ? '0 : r_row;
        w_word_last = (w_word_col == COL_LAST);
        w_col_next  = w_word_last ? '0 : w_word_col + COL_W'(1);
        w_row_next  = !w_word_last             ? w_word_row :
                      (w_word_row == ROW_LAST) ? '0 : w_word_row + ROW_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_UNSYNCED;
        else     r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_word_valid    = 1'b0;
        w_frame_err_set = 1'b0;
        case (r_state)
            ST_UNSYNCED: begin
                if (w_acc && w_sof) begin
                    w_state_next = ST_SYNCED;
                    w_word_valid = 1'b1;
                end
            end
            ST_SYNCED: begin
                if (w_acc) begin
                    w_word_valid    = 1'b1;
                    w_frame_err_set = w_sof ^ w_at_origin;
                end
            end
            default: w_state_next = ST_UNSYNCED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_word_valid) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    assign w_pixel = show_color_depth ? sat_shift(disparity[7:0], DISP_SHIFT)
                                      : disparity[7:0];
    assign w_word  = '{tuser: (w_word_col == '0) && (w_word_row == '0),
                       tlast: w_word_last,
                       data:  w_pixel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_stage_word  <= '0;
        end else begin
            r_stage_valid <= w_word_valid;
            if (w_acc) r_stage_word <= w_word;
        end
    end

    // The pipeline cannot stall, so a full FIFO drops the word instead.
    assign w_pop  = m_axis.tvalid && m_axis.tready;
    assign w_push = r_stage_valid && (!w_full || w_pop);

    axis_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(axis_word_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (r_stage_word),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_axis.tvalid = !w_empty;
    assign m_axis.tdata  = w_empty ? '0 : w_head.data;
    assign m_axis.tuser  = w_empty ? 1'b0 : w_head.tuser;
    assign m_axis.tlast  = w_empty ? 1'b0 : w_head.tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (r_stage_valid && !w_push) overflow  <= 1'b1;
            if (w_frame_err_set)          frame_err <= 1'b1;
        end
    end

endmodule

// File: doc/disparity_axis_tx.md
# disparity_axis_tx

Output-side converter for the stereo pipeline. It consumes the SOF-tagged 9-bit disparity stream that the pipeline produces under the `en`/`pixelEN` cadence, recovers row and column position, and maps each disparity to an 8-bit pixel. Pixels are buffered in a small FIFO and re-emitted as an AXI4-Stream video master (`tuser` = start of frame, `tlast` = end of line) toward VDMA/HDMI. The pipeline cannot stall, so overflow is detected and flagged rather than back-pressured.

## Interface
- `IMAGE_WIDTH`, 640, pixels per line
- `IMAGE_HEIGHT`, 480, lines per frame
- `INPUTDATAWID`, 9, bit 8 = SOF, bits 7:0 = disparity
- `FIFO_DEPTH`, 16, power of two, ≥ 4
- `DISP_SHIFT`, 2, left shift applied in depth-display mode
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `en`  in  1  global pipeline enable
- `pixelEN`  in  1  pixel strobe; input sampled only when `en & pixelEN`
- `disparity`  in  9  SOF-tagged disparity
- `show_color_depth`  in  1  1 = scaled depth view, 0 = raw disparity
- `m_axis_tdata`  out  8  output pixel
- `m_axis_tvalid`  out  1  AXI valid
- `m_axis_tready`  in  1  AXI ready
- `m_axis_tuser`  out  1  first pixel of frame
- `m_axis_tlast`  out  1  last pixel of line
- `overflow`  out  1  sticky: a word was dropped on a full FIFO
- `frame_err`  out  1  sticky: SOF misplaced or missing

## Operation
- Accept strobe: `acc = en & pixelEN`. The AXI side runs independently of `en`.
- Unsynced after reset. While unsynced, non-SOF inputs are discarded. The first accepted SOF sets synced.
- Position counters: `col` runs 0..W-1 and `row` runs 0..H-1. They advance on every accepted word while synced. `col` wraps at W-1 and increments `row`; `row` wraps at H-1.
- SOF on an accepted word:
  - Forces position (0,0) for that word.
  - If synced and the expected position was not (0,0), set `frame_err` (resync).
- Expected position (0,0) with no SOF: counters wrap, the word is still tagged `tuser`, and `frame_err` is set.
- Pixel mapping:
  - `show_color_depth=1`: `min(disparity[7:0] << DISP_SHIFT, 255)`, saturating.
  - `show_color_depth=0`: `disparity[7:0]`.
- Stage register: holds `{tuser = (row==0 && col==0), tlast = (col==W-1), pixel}` plus a valid bit. It updates only on `acc`; its valid bit is cleared when `acc` is low.
- FIFO write: occurs when the stage is valid and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
- FIFO read: pop on `m_axis_tvalid & m_axis_tready`.
- `m_axis_tvalid = !empty`. `tdata`/`tuser`/`tlast` are the head word, stable while `tvalid & !tready`.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - All outputs 0.
  - Counters 0, synced 0.
  - FIFO empty.
  - Stage valid 0.
- Latency: an input accepted in cycle N is registered at the end of N. It is written to the FIFO at the end of N+1. `m_axis_tvalid` is high in N+2 if the FIFO was empty.
- Throughput: one word per cycle both in and out. A full-rate push and pop in the same cycle leaves occupancy unchanged.
- Full/empty are decided on occupancy before the edge.
- Reset mid-frame: the FIFO is flushed, the block returns unsynced, and output restarts at the next SOF.
- Occupancy never exceeds `FIFO_DEPTH`. Pointers are log2(`FIFO_DEPTH`)+1 bits wide, with the MSB used to tell full from empty.

## Structure
- Shared package `stereo_pkg` holds:
  - `IMAGE_WIDTH`, `IMAGE_HEIGHT`, `MAXDISPARITY`
  - SOF bit index (8) and disparity width (8)
  - the `axis_word_t` struct `{tuser, tlast, data[7:0]}`
- Sub-module `axis_word_fifo`: synchronous FIFO with first-word-fall-through output, parameterised depth and width, and push/pop/full/empty ports.
- The top level contains the sync/position logic, pixel mapping, stage register, and flag logic.

## Test plan
- Full frame at W=8, H=4, `tready`=1, `pixelEN` every 8th cycle, raw mode: 32 beats out with data equal to input. `tuser` on beat 0 only, `tlast` on beats 7/15/23/31. First `tvalid` 2 cycles after the first accept. Flags stay 0.
- Depth mode, `DISP_SHIFT`=2, inputs 10, 63, 64, 200: output 40, 252, 255, 255.
- Five non-SOF words before the first SOF: none emitted. Output starts at the SOF word with `tuser`=1.
- SOF injected at col 5 row 2: `frame_err`=1, that word has `tuser`=1, and the following 7 beats carry `tlast` on the 8th word after the SOF.
- `tready`=0 with `pixelEN` every cycle, `FIFO_DEPTH`=16: 16 words are buffered and the 17th sets `overflow`. Raising `tready` drains exactly 16 words in order. A push and pop in the same cycle at full: no drop.
- `rst` pulsed mid-line with 6 words queued: `tvalid` drops immediately. The next frame's SOF restarts output with `tuser`=1 and the flags cleared.
